// File: rtl/ahb_cmd_queue.sv
// Command queue feeding the AHB master: FIFO of {write, addr, data} requests,
// one-at-a-time issue with READY handshake and a per-transfer watchdog.
module ahb_cmd_queue #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [DATA_W-1:0]        req_data,
   output logic                     VALID,
   output logic                     WRITE,
   output logic [ADDR_W-1:0]        ADDR,
   output logic [DATA_W-1:0]        DATA,
   input  logic                     READY,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     done_pulse,
   output logic                     timeout_err,
   input  logic                     err_clr
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int WD_W    = $clog2(TIMEOUT);
   localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   logic [ENTRY_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [LVL_W-1:0]  level_reg, level_next;
   logic              full_reg;
   logic              empty;
   logic              push, pop, drop, done;
   state_t            state_reg, state_next;
   logic [WD_W-1:0]   wdog_reg, wdog_next;
   logic              write_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;
   logic              err_reg;

   assign empty     = (level_reg == '0);
   assign req_ready = !full_reg;
   assign push      = req_valid && !full_reg;

   // Storage array: no reset so it maps onto block RAM.
   always_ff @(posedge HCLK) begin
      if (push) begin
         mem[wr_ptr_reg] <= {req_write, req_addr, req_data};
      end
   end

   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         full_reg   <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         level_reg <= level_next;
         full_reg  <= (level_next == LVL_FULL);
      end
   end

   // Issue FSM: IDLE loads the head, BUSY waits for READY or watchdog expiry.
   always_comb begin
      state_next = state_reg;
      wdog_next  = wdog_reg;
      pop        = 1'b0;
      done       = 1'b0;
      drop       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               wdog_next  = '0;
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (READY) begin
               done       = 1'b1;
               state_next = ST_IDLE;
            end else if (wdog_reg == WD_LAST) begin
               drop       = 1'b1;
               state_next = ST_IDLE;
            end else begin
               wdog_next = wdog_reg + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg <= ST_IDLE;
         wdog_reg  <= '0;
      end else begin
         state_reg <= state_next;
         wdog_reg  <= wdog_next;
      end
   end

   // Command registers double as the array's registered read port.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         write_reg <= 1'b0;
         addr_reg  <= '0;
         data_reg  <= '0;
      end else if (pop) begin
         {write_reg, addr_reg, data_reg} <= mem[rd_ptr_reg];
      end
   end

   // A drop in the same cycle as err_clr leaves the flag set.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_reg <= 1'b0;
      end else if (drop) begin
         err_reg <= 1'b1;
      end else if (err_clr) begin
         err_reg <= 1'b0;
      end
   end

   assign VALID       = (state_reg == ST_BUSY);
   assign WRITE       = write_reg;
   assign ADDR        = addr_reg;
   assign DATA        = data_reg;
   assign level       = level_reg;
   assign done_pulse  = done;
   assign timeout_err = err_reg;

endmodule

// File: tb/tb_ahb_cmd_queue.sv
// Directed bench for ahb_cmd_queue (DEPTH=4, ADDR_W=4, DATA_W=32, TIMEOUT=16).
module tb_ahb_cmd_queue;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [3:0]  req_addr;
   logic [31:0] req_data;
   logic        VALID;
   logic        WRITE;
   logic [3:0]  ADDR;
   logic [31:0] DATA;
   logic        READY;
   logic [2:0]  level;
   logic        done_pulse;
   logic        timeout_err;
   logic        err_clr;

   int checks   = 0;
   int failures = 0;

   ahb_cmd_queue #(
      .DEPTH  (4),
      .ADDR_W (4),
      .DATA_W (32),
      .TIMEOUT(16)
   ) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .VALID      (VALID),
      .WRITE      (WRITE),
      .ADDR       (ADDR),
      .DATA       (DATA),
      .READY      (READY),
      .level      (level),
      .done_pulse (done_pulse),
      .timeout_err(timeout_err),
      .err_clr    (err_clr)
   );

   always #5 HCLK = ~HCLK;

   task automatic drive_req(input logic v, input logic [3:0] a);
      req_valid = v;
      req_write = a[0];
      req_addr  = a;
      req_data  = {28'hA5A5_A5A, a};
   endtask

   task automatic do_reset();
      @(negedge HCLK);
      HRESETn = 1'b0;
      drive_req(1'b0, 4'h0);
      READY   = 1'b0;
      err_clr = 1'b0;
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      drive_req(1'b0, 4'h0);
      READY   = 1'b0;
      err_clr = 1'b0;
      #1;
      checks++;
      if ({VALID, WRITE, ADDR, DATA, done_pulse, timeout_err, req_ready, level} !==
          {1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
         failures++;
         $display("FAIL reset_state: got V=%b W=%b A=%h D=%h dp=%b te=%b rr=%b lvl=%0d, expected all 0 except req_ready=1",
                  VALID, WRITE, ADDR, DATA, done_pulse, timeout_err, req_ready, level);
      end
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      READY     = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 4'h3;
      req_data  = 32'hDEADBEEF;
      @(negedge HCLK);
      req_valid = 1'b0;
      checks++;
      if (VALID !== 1'b0 || level !== 3'd1) begin
         failures++;
         $display("FAIL single_store: VALID=%b level=%0d, expected VALID=0 level=1", VALID, level);
      end
      @(negedge HCLK);
      checks++;
      if ({VALID, WRITE, ADDR, DATA, done_pulse, level} !== {1'b1, 1'b1, 4'h3, 32'hDEADBEEF, 1'b1, 3'd0}) begin
         failures++;
         $display("FAIL single_issue: V=%b W=%b A=%h D=%h dp=%b lvl=%0d, expected 1 1 3 deadbeef 1 0",
                  VALID, WRITE, ADDR, DATA, done_pulse, level);
      end
      @(negedge HCLK);
      checks++;
      if (VALID !== 1'b0 || done_pulse !== 1'b0) begin
         failures++;
         $display("FAIL single_end: VALID=%b done_pulse=%b, expected 0 0", VALID, done_pulse);
      end
      READY = 1'b0;
      $display("test_single done");
   endtask

   task automatic test_back_to_back();
      int exp_addr;
      do_reset();
      READY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_req(1'b1, 4'(i));
         @(negedge HCLK);
      end
      drive_req(1'b0, 4'h0);
      checks++;
      if (level !== 3'd4 || req_ready !== 1'b0 || VALID !== 1'b1 || ADDR !== 4'h0) begin
         failures++;
         $display("FAIL b2b_full: level=%0d req_ready=%b VALID=%b ADDR=%h, expected 4 0 1 0",
                  level, req_ready, VALID, ADDR);
      end
      READY    = 1'b1;
      exp_addr = 0;
      for (int c = 0; c < 30 && exp_addr < 5; c++) begin
         #1;
         if (done_pulse) begin
            checks++;
            if (ADDR !== 4'(exp_addr)) begin
               failures++;
               $display("FAIL b2b_order: ADDR=%h, expected %h", ADDR, 4'(exp_addr));
            end
            exp_addr++;
         end
         @(negedge HCLK);
      end
      READY = 1'b0;
      checks++;
      if (exp_addr !== 5 || level !== 3'd0) begin
         failures++;
         $display("FAIL b2b_count: done_pulses=%0d level=%0d, expected 5 0", exp_addr, level);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_timeout();
      int cnt;
      int saw_done;
      do_reset();
      READY = 1'b0;
      drive_req(1'b1, 4'h5);
      @(negedge HCLK);
      drive_req(1'b1, 4'h6);
      @(negedge HCLK);
      drive_req(1'b0, 4'h0);
      cnt      = 0;
      saw_done = 0;
      while (VALID === 1'b1 && cnt < 40) begin
         if (done_pulse) saw_done++;
         cnt++;
         @(negedge HCLK);
      end
      checks++;
      if (cnt !== 16 || timeout_err !== 1'b1 || saw_done !== 0) begin
         failures++;
         $display("FAIL timeout_drop: valid_cycles=%0d timeout_err=%b done_pulses=%0d, expected 16 1 0",
                  cnt, timeout_err, saw_done);
      end
      @(negedge HCLK);
      checks++;
      if (VALID !== 1'b1 || ADDR !== 4'h6) begin
         failures++;
         $display("FAIL timeout_next: VALID=%b ADDR=%h, expected 1 6", VALID, ADDR);
      end
      err_clr = 1'b1;
      @(negedge HCLK);
      err_clr = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL err_clr: timeout_err=%b, expected 0", timeout_err);
      end
      READY = 1'b1;
      @(negedge HCLK);
      READY = 1'b0;
      $display("test_timeout done");
   endtask

   task automatic test_expiry_ready();
      do_reset();
      READY = 1'b0;
      drive_req(1'b1, 4'h9);
      @(negedge HCLK);
      drive_req(1'b0, 4'h0);
      @(negedge HCLK);
      for (int i = 1; i < 16; i++) @(negedge HCLK);
      checks++;
      if (VALID !== 1'b1) begin
         failures++;
         $display("FAIL expiry_pre: VALID=%b in 16th cycle, expected 1", VALID);
      end
      READY = 1'b1;
      #1;
      checks++;
      if (done_pulse !== 1'b1) begin
         failures++;
         $display("FAIL expiry_done: done_pulse=%b, expected 1", done_pulse);
      end
      @(negedge HCLK);
      READY = 1'b0;
      checks++;
      if (VALID !== 1'b0 || timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL expiry_err: VALID=%b timeout_err=%b, expected 0 0", VALID, timeout_err);
      end
      $display("test_expiry_ready done");
   endtask

   task automatic test_push_pop();
      int nxt;
      int exp_done;
      logic accept;
      do_reset();
      READY = 1'b0;
      drive_req(1'b1, 4'h0);
      @(negedge HCLK);
      drive_req(1'b1, 4'h1);
      @(negedge HCLK);
      drive_req(1'b1, 4'h2);
      @(negedge HCLK);
      drive_req(1'b0, 4'h0);
      READY = 1'b1;
      @(negedge HCLK);
      checks++;
      if (level !== 3'd2 || VALID !== 1'b0) begin
         failures++;
         $display("FAIL pp_pre: level=%0d VALID=%b, expected 2 0", level, VALID);
      end
      READY = 1'b0;
      drive_req(1'b1, 4'h3);
      @(negedge HCLK);
      checks++;
      if (level !== 3'd2 || VALID !== 1'b1 || ADDR !== 4'h1) begin
         failures++;
         $display("FAIL pp_same_cycle: level=%0d VALID=%b ADDR=%h, expected 2 1 1", level, VALID, ADDR);
      end
      nxt      = 4;
      exp_done = 1;
      READY    = 1'b1;
      for (int c = 0; c < 60 && exp_done < 8; c++) begin
         drive_req(nxt < 8, 4'(nxt));
         #1;
         if (done_pulse) begin
            checks++;
            if (ADDR !== 4'(exp_done)) begin
               failures++;
               $display("FAIL pp_order: ADDR=%h, expected %h", ADDR, 4'(exp_done));
            end
            exp_done++;
         end
         accept = req_valid && req_ready;
         @(negedge HCLK);
         if (accept) nxt++;
      end
      drive_req(1'b0, 4'h0);
      READY = 1'b0;
      checks++;
      if (exp_done !== 8 || nxt !== 8) begin
         failures++;
         $display("FAIL pp_wrap: completed up to %0d pushed %0d, expected 8 8", exp_done, nxt);
      end
      $display("test_push_pop done");
   endtask

   task automatic test_reset_busy();
      do_reset();
      READY = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive_req(1'b1, 4'(i));
         @(negedge HCLK);
      end
      drive_req(1'b0, 4'h0);
      checks++;
      if (level !== 3'd3 || VALID !== 1'b1) begin
         failures++;
         $display("FAIL rb_pre: level=%0d VALID=%b, expected 3 1", level, VALID);
      end
      #2;
      HRESETn = 1'b0;
      #1;
      checks++;
      if (VALID !== 1'b0 || level !== 3'd0 || req_ready !== 1'b1 || done_pulse !== 1'b0) begin
         failures++;
         $display("FAIL rb_async: VALID=%b level=%0d req_ready=%b done_pulse=%b, expected 0 0 1 0",
                  VALID, level, req_ready, done_pulse);
      end
      @(negedge HCLK);
      HRESETn = 1'b1;
      READY   = 1'b1;
      drive_req(1'b1, 4'h7);
      @(negedge HCLK);
      drive_req(1'b0, 4'h0);
      @(negedge HCLK);
      checks++;
      if (VALID !== 1'b1 || ADDR !== 4'h7 || done_pulse !== 1'b1) begin
         failures++;
         $display("FAIL rb_post: VALID=%b ADDR=%h done_pulse=%b, expected 1 7 1", VALID, ADDR, done_pulse);
      end
      READY = 1'b0;
      $display("test_reset_busy done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_timeout();
      test_expiry_ready();
      test_push_pop();
      test_reset_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
